// File: rtl/fm_param_pkg.sv
// Shared types and default dimensions for the oscillator parameter bus bridge.
// Holds the default regfile geometry, index/word typedefs and the bridge FSM state enum.
package fm_param_pkg;

    localparam int unsigned NUMOSCS   = 12;
    localparam int unsigned NUMPARAMS = 24;
    localparam int unsigned PARAMW    = 5;
    localparam int unsigned OSCW      = 4;
    localparam int unsigned CNTW      = 16;
    localparam int unsigned WORDW     = 32;

    typedef logic [OSCW-1:0]   osc_idx_t;
    typedef logic [PARAMW-1:0] param_idx_t;
    typedef logic [WORDW-1:0]  param_word_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } bridge_state_t;

endpackage

// File: rtl/param_addr_decode.sv
// Combinational address decoder for the parameter regfile.
// Ports:
//   addr      - word address {osc, param}
//   osc_idx   - oscillator index field
//   param_idx - parameter index field
//   in_range  - both indices address an existing regfile entry
//   sel       - one-hot [osc][param] select matrix, all-zero when out of range
module param_addr_decode #(
    parameter int unsigned NUMOSCS   = fm_param_pkg::NUMOSCS,
    parameter int unsigned NUMPARAMS = fm_param_pkg::NUMPARAMS,
    parameter int unsigned OSCW      = fm_param_pkg::OSCW,
    parameter int unsigned PARAMW    = fm_param_pkg::PARAMW
) (
    input  logic [OSCW+PARAMW-1:0]           addr,
    output logic [OSCW-1:0]                  osc_idx,
    output logic [PARAMW-1:0]                param_idx,
    output logic                             in_range,
    output logic [NUMOSCS-1:0][NUMPARAMS-1:0] sel
);

    assign osc_idx   = addr[OSCW+PARAMW-1:PARAMW];
    assign param_idx = addr[PARAMW-1:0];
    assign in_range  = (32'(osc_idx) < NUMOSCS) && (32'(param_idx) < NUMPARAMS);

    // One-hot select; an out-of-range index matches no row/column.
    always_comb begin
        sel = '0;
        for (int o = 0; o < int'(NUMOSCS); o++) begin
            for (int p = 0; p < int'(NUMPARAMS); p++) begin
                sel[o][p] = in_range && (osc_idx == OSCW'(o)) && (param_idx == PARAMW'(p));
            end
        end
    end

endmodule

// File: rtl/param_bus_bridge.sv
// Avalon-MM slave giving word access to the oscillator parameter regfile.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   avs_*              - Avalon-MM slave (address = {osc, param}, waitrequest handshake)
//   rf_wren / rf_rden  - one-hot per-entry write/read strobes to the regfile
//   rf_wdata           - latched write word broadcast to every entry
//   rf_rdata           - registered read words from the regfile
//   bad_access_cnt     - saturating count of out-of-range or read+write accesses
module param_bus_bridge #(
    parameter int unsigned NUMOSCS   = fm_param_pkg::NUMOSCS,
    parameter int unsigned NUMPARAMS = fm_param_pkg::NUMPARAMS,
    parameter int unsigned PARAMW    = fm_param_pkg::PARAMW,
    parameter int unsigned OSCW      = fm_param_pkg::OSCW,
    parameter int unsigned CNTW      = fm_param_pkg::CNTW
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [OSCW+PARAMW-1:0]                 avs_address,
    input  logic                                   avs_read,
    input  logic                                   avs_write,
    input  logic [31:0]                            avs_writedata,
    output logic [31:0]                            avs_readdata,
    output logic                                   avs_waitrequest,
    output logic [NUMOSCS-1:0][NUMPARAMS-1:0]       rf_wren,
    output logic [NUMOSCS-1:0][NUMPARAMS-1:0]       rf_rden,
    output logic [NUMOSCS-1:0][NUMPARAMS-1:0][31:0] rf_wdata,
    input  logic [NUMOSCS-1:0][NUMPARAMS-1:0][31:0] rf_rdata,
    output logic [CNTW-1:0]                        bad_access_cnt
);

    import fm_param_pkg::*;

    localparam int unsigned AW = OSCW + PARAMW;

    bridge_state_t state_q, state_d;
    logic [AW-1:0] addr_q;
    param_word_t   wdata_q;
    logic          both_q;
    logic          latch_addr, latch_wdata, count_bad;

    logic [OSCW-1:0]                  osc_idx;
    logic [PARAMW-1:0]                param_idx;
    logic                             in_range;
    logic [NUMOSCS-1:0][NUMPARAMS-1:0] sel;

    // Decode only the latched address so strobes never follow the live bus.
    param_addr_decode #(
        .NUMOSCS  (NUMOSCS),
        .NUMPARAMS(NUMPARAMS),
        .OSCW     (OSCW),
        .PARAMW   (PARAMW)
    ) u_decode (
        .addr     (addr_q),
        .osc_idx  (osc_idx),
        .param_idx(param_idx),
        .in_range (in_range),
        .sel      (sel)
    );

    // Next-state logic; bad accesses are counted once, in the cycle after acceptance.
    always_comb begin
        state_d     = state_q;
        latch_addr  = 1'b0;
        latch_wdata = 1'b0;
        count_bad   = 1'b0;
        case (state_q)
            IDLE: begin
                if (avs_write) begin
                    state_d     = WR;
                    latch_addr  = 1'b1;
                    latch_wdata = 1'b1;
                end else if (avs_read) begin
                    state_d    = RD_ISSUE;
                    latch_addr = 1'b1;
                end
            end
            WR: begin
                state_d   = IDLE;
                count_bad = !in_range || both_q;
            end
            RD_ISSUE: begin
                state_d   = RD_WAIT;
                count_bad = !in_range;
            end
            RD_WAIT:  state_d = RD_DONE;
            RD_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, latched request and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            both_q          <= 1'b0;
            avs_waitrequest <= 1'b1;
            avs_readdata    <= '0;
            bad_access_cnt  <= '0;
        end else begin
            state_q         <= state_d;
            avs_waitrequest <= !((state_d == WR) || (state_d == RD_DONE));
            if (latch_addr) begin
                addr_q <= avs_address;
                both_q <= avs_read && avs_write;
            end
            if (latch_wdata) begin
                wdata_q <= avs_writedata;
            end
            if (state_q == RD_WAIT) begin
                avs_readdata <= in_range ? rf_rdata[osc_idx][param_idx] : 32'h0;
            end
            if (count_bad && (bad_access_cnt != '1)) begin
                bad_access_cnt <= bad_access_cnt + CNTW'(1);
            end
        end
    end

    // Strobes are the registered select gated by the registered state.
    assign rf_wren  = (state_q == WR)       ? sel : '0;
    assign rf_rden  = (state_q == RD_ISSUE) ? sel : '0;
    assign rf_wdata = {(NUMOSCS*NUMPARAMS){wdata_q}};

endmodule
